lsu_mem_ctrl: RTL

Load/store unit sitting directly downstream of the instruction decoder's control word. It receives the decoder's memory-enable (bus-lock) and memory-mode (read/write) bits, the instruction's funct3, the ALU-computed effective address and rs2 store data. It runs one request/acknowledge transaction on the word-wide data bus, with byte-lane steering, load sign/zero extension, alignment checking and a bus timeout. While the access is outstanding it stalls the core, then hands the load result to register writeback.

---
 rtl/lsu_bus_if.sv | 21 ++
 rtl/lsu_mem_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_if.sv
// Word-wide request/acknowledge data bus between the load/store unit and memory.
// The master drives the request phase; the slave answers with ack and read data.
interface lsu_bus_if;
   logic        req;
   logic        we;
   logic [29:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one bus transaction per request with lane steering, load extension,
// alignment/width checking and an ack timeout. Stalls the core while the access is open.
module lsu_mem_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             we_i,
   input  logic [2:0]       funct3_i,
   input  logic [31:0]      addr_i,
   input  logic [31:0]      wdata_i,
   output logic             stall_o,
   output logic             done_o,
   output logic [31:0]      rdata_o,
   output logic             fault_o,
   output logic [1:0]       fault_code_o,
   lsu_bus_if.master        bus
);

   localparam bit               TimeoutEn   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StBus, StDone, StFault} state_e;

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        off_q, off_d;
   logic [29:0]       addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        code_q, code_d;

   logic [3:0]  be_in;
   logic [31:0] wdata_in;
   logic        illegal;
   logic        misaligned;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_ext;
   logic        in_bus;

   // Request-side decode from the live decoder/ALU inputs, used only on the start cycle.
   always_comb begin
      be_in    = 4'b0000;
      wdata_in = wdata_i;
      unique case (funct3_i[1:0])
         2'b00: begin
            be_in    = 4'b0001 << addr_i[1:0];
            wdata_in = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_in    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{wdata_i[15:0]}};
         end
         2'b10: be_in = 4'b1111;
         default: be_in = 4'b0000;
      endcase
   end

   always_comb begin
      if (we_i) begin
         illegal = (funct3_i != 3'b000) && (funct3_i != 3'b001) && (funct3_i != 3'b010);
      end else begin
         illegal = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
      end
      misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
   end

   // Load extraction works from the latched offset, not the live address.
   always_comb begin
      rd_byte = bus.rdata[{off_q, 3'b000} +: 8];
      rd_half = off_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
      unique case (funct3_q)
         3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
         3'b100:  load_ext = {24'b0, rd_byte};
         3'b101:  load_ext = {16'b0, rd_half};
         default: load_ext = bus.rdata;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      off_d    = off_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      code_d   = code_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               we_d     = we_i;
               funct3_d = funct3_i;
               off_d    = addr_i[1:0];
               addr_d   = addr_i[31:2];
               be_d     = be_in;
               wdata_d  = wdata_in;
               cnt_d    = '0;
               if (illegal) begin
                  state_d = StFault;
                  code_d  = 2'b11;
               end else if (misaligned) begin
                  state_d = StFault;
                  code_d  = 2'b01;
               end else begin
                  state_d = StBus;
               end
            end
         end
         StBus: begin
            if (bus.ack) begin
               if (!we_q) rdata_d = load_ext;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (TimeoutEn && (cnt_q == TimeoutLast)) begin
                  state_d = StFault;
                  code_d  = 2'b10;
               end
            end
         end
         StDone:  state_d = StIdle;
         StFault: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         off_q    <= 2'b00;
         addr_q   <= '0;
         be_q     <= 4'b0000;
         wdata_q  <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         code_q   <= 2'b00;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         off_q    <= off_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         code_q   <= code_d;
      end
   end

   assign in_bus = (state_q == StBus);

   // Bus lines are gated so the bus is quiet whenever no request is outstanding.
   assign bus.req   = in_bus;
   assign bus.we    = in_bus & we_q;
   assign bus.addr  = in_bus ? addr_q : '0;
   assign bus.be    = in_bus ? be_q : 4'b0000;
   assign bus.wdata = in_bus ? wdata_q : '0;

   assign stall_o      = in_bus | ((state_q == StIdle) & start_i);
   assign done_o       = (state_q == StDone);
   assign fault_o      = (state_q == StFault);
   assign rdata_o      = rdata_q;
   assign fault_code_o = code_q;

endmodule
